// File: rtl/conv2d_asymmetric_kernel_stream_module_if.sv
// Stream bundle for the conv2d engine: weight load channel, frame load channel,
// result channel plus the reload request and end-of-frame pulse.
interface conv2d_asymmetric_kernel_stream_module_if #(
    parameter int DATA_W   = 16,
    parameter int OUT_BITS = 32
);
    logic                       weight_valid;
    logic                       weight_ready;
    logic signed [DATA_W-1:0]   weight_data;
    logic                       valid_in;
    logic                       ready_in;
    logic signed [DATA_W-1:0]   input_data;
    logic                       reload_w;
    logic                       valid_out;
    logic                       ready_out;
    logic signed [OUT_BITS-1:0] output_data;
    logic                       frame_done;

    modport master (
        output weight_valid, weight_data, valid_in, input_data, reload_w, ready_out,
        input  weight_ready, ready_in, valid_out, output_data, frame_done
    );

    modport slave (
        input  weight_valid, weight_data, valid_in, input_data, reload_w, ready_out,
        output weight_ready, ready_in, valid_out, output_data, frame_done
    );
endinterface

// File: rtl/conv2d_asymmetric_kernel_stream_module.sv
// Single-channel 2D cross-correlation (no padding, asymmetric K_H x K_W kernel):
// buffers weights and one input frame, then walks every output with one serial MAC.
module conv2d_asymmetric_kernel_stream_module #(
    parameter int IN_H     = 5,
    parameter int IN_W     = 7,
    parameter int K_H      = 3,
    parameter int K_W      = 2,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 1,
    parameter int DATA_W   = 16,
    parameter int OUT_BITS = 32
) (
    input  logic clk,
    input  logic rst,
    conv2d_asymmetric_kernel_stream_module_if.slave bus
);
    localparam int OUT_ROWS = (IN_H - K_H) / STRIDE_H + 1;
    localparam int OUT_COLS = (IN_W - K_W) / STRIDE_W + 1;
    localparam int NTAP     = K_H * K_W;
    localparam int NPIX     = IN_H * IN_W;
    localparam int PROD_W   = 2 * DATA_W;
    localparam int ACC_W    = PROD_W + $clog2(NTAP);

    localparam int WC_W = (NTAP > 1)     ? $clog2(NTAP)     : 1;
    localparam int XC_W = (NPIX > 1)     ? $clog2(NPIX)     : 1;
    localparam int KH_W = (K_H > 1)      ? $clog2(K_H)      : 1;
    localparam int KW_W = (K_W > 1)      ? $clog2(K_W)      : 1;
    localparam int OH_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int OW_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(OUT_BITS-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [1:0] {S_LOAD_W, S_LOAD_X, S_MAC, S_OUT} state_t;

    state_t state_q, state_d;

    logic [WC_W-1:0] wcnt;
    logic [XC_W-1:0] xcnt;
    logic [KH_W-1:0] kh;
    logic [KW_W-1:0] kw;
    logic [OH_W-1:0] oh;
    logic [OW_W-1:0] ow;

    logic signed [ACC_W-1:0]    acc;
    logic signed [OUT_BITS-1:0] out_q;

    logic signed [DATA_W-1:0] w_mem [NTAP];
    logic signed [DATA_W-1:0] x_mem [NPIX];

    logic w_hs, x_hs, o_hs;
    logic last_w, last_x, last_tap, last_col, last_row;

    assign w_hs = (state_q == S_LOAD_W) && bus.weight_valid;
    assign x_hs = (state_q == S_LOAD_X) && bus.valid_in;
    assign o_hs = (state_q == S_OUT)    && bus.ready_out;

    assign last_w   = (wcnt == WC_W'(NTAP - 1));
    assign last_x   = (xcnt == XC_W'(NPIX - 1));
    assign last_tap = (kh == KH_W'(K_H - 1)) && (kw == KW_W'(K_W - 1));
    assign last_col = (ow == OW_W'(OUT_COLS - 1));
    assign last_row = (oh == OH_W'(OUT_ROWS - 1));

    // NOTE: every register uses non-blocking assignment so all flops sample
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_LOAD_W;
        else     state_q <= state_d;
    end

    // NOTE: each output gets a default before the case so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        bus.weight_ready = 1'b0;
        bus.ready_in     = 1'b0;
        bus.valid_out    = 1'b0;
        bus.frame_done   = 1'b0;
        unique case (state_q)
            S_LOAD_W: begin
                bus.weight_ready = 1'b1;
                if (bus.weight_valid && last_w) state_d = S_LOAD_X;
            end
            S_LOAD_X: begin
                bus.ready_in = 1'b1;
                if (bus.valid_in) begin
                    if (last_x) state_d = S_MAC;
                end else if (bus.reload_w && (xcnt == '0)) begin
                    state_d = S_LOAD_W;
                end
            end
            S_MAC: begin
                if (last_tap) state_d = S_OUT;
            end
            S_OUT: begin
                bus.valid_out = 1'b1;
                if (bus.ready_out) begin
                    bus.frame_done = last_row && last_col;
                    state_d        = (last_row && last_col) ? S_LOAD_X : S_MAC;
                end
            end
            default: state_d = S_LOAD_W;
        endcase
    end

    // Tap addressing: weight[kh][kw] against x[oh*SH+kh][ow*SW+kw].
    logic [WC_W-1:0]          w_addr;
    logic [XC_W-1:0]          x_addr;
    logic signed [PROD_W-1:0] w_ext, x_ext, prod;
    logic signed [ACC_W-1:0]  acc_sum;

    assign w_addr  = WC_W'(int'(kh) * K_W + int'(kw));
    assign x_addr  = XC_W'((int'(oh) * STRIDE_H + int'(kh)) * IN_W + int'(ow) * STRIDE_W + int'(kw));
    assign w_ext   = PROD_W'(w_mem[w_addr]);
    assign x_ext   = PROD_W'(x_mem[x_addr]);
    assign prod    = w_ext * x_ext;
    assign acc_sum = ((kh == '0) && (kw == '0) ? '0 : acc) + ACC_W'(prod);

    function automatic logic signed [OUT_BITS-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[OUT_BITS-1:0];
        else if (v < SAT_MIN) return SAT_MIN[OUT_BITS-1:0];
        else                  return v[OUT_BITS-1:0];
    endfunction

    // NOTE: the weight and frame buffers have no reset; stale contents are
    // harmless because the counters and FSM force a full reload before use.
    always_ff @(posedge clk) begin
        if (!rst && w_hs) w_mem[wcnt] <= bus.weight_data;
        if (!rst && x_hs) x_mem[xcnt] <= bus.input_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt  <= '0;
            xcnt  <= '0;
            kh    <= '0;
            kw    <= '0;
            oh    <= '0;
            ow    <= '0;
            acc   <= '0;
            out_q <= '0;
        end else begin
            if (w_hs) wcnt <= last_w ? '0 : wcnt + 1'b1;
            if (x_hs) xcnt <= last_x ? '0 : xcnt + 1'b1;
            if (state_q == S_MAC) begin
                acc <= acc_sum;
                if (kw == KW_W'(K_W - 1)) begin
                    kw <= '0;
                    kh <= last_tap ? '0 : kh + 1'b1;
                end else begin
                    kw <= kw + 1'b1;
                end
                if (last_tap) out_q <= saturate(acc_sum);
            end
            if (o_hs) begin
                if (last_col) begin
                    ow <= '0;
                    oh <= last_row ? '0 : oh + 1'b1;
                end else begin
                    ow <= ow + 1'b1;
                end
            end
        end
    end

    assign bus.output_data = out_q;
endmodule
